l1_cache_2way: RTL and testbench
================================

Name: l1_cache_2way

Overview:
- 2-way set-associative, write-back, write-allocate L1 cache between the LC-3b CPU memory port (16-bit words) and physical memory (128-bit lines).
- Address split per lc3b_types: tag[15:7] (lc3b_c_tag), index[6:4] (lc3b_c_index, 8 sets), offset[3:0] (lc3b_c_offset, 16-byte line).
- One instance each for I-side and D-side; CPU-facing handshake matches the existing mem_read/mem_write/mem_resp convention.

Parameters:
- NUM_SETS, 8, sets per way; must equal 2**$bits(lc3b_c_index), elaboration error otherwise.
- LINE_BITS, 128, line width; must equal $bits(lc3b_mem_data).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_address  in  16  CPU byte address; bit 0 ignored.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- mem_byte_enable  in  2  lc3b_mem_wmask; [1]=high byte, [0]=low byte.
- mem_wdata  in  16  CPU write word.
- mem_rdata  out  16  read word, registered, valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  16  line address, offset bits forced to 0.
- pmem_read  out  1  line fill request, held until pmem_resp.
- pmem_write  out  1  line writeback request, held until pmem_resp.
- pmem_wdata  out  128  victim line data.
- pmem_rdata  in  128  fill data, valid with pmem_resp.
- pmem_resp  in  1  physical memory completion.

Behaviour:
- Reset (async assert, any state): state=IDLE; all valid, dirty and LRU bits=0; mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0. Tag/data arrays not reset. Any in-flight pmem transaction is abandoned; the CPU must reissue its request.
- State IDLE:
  - No request: stay.
  - Request with hit (valid && tag match in way w): read latches word offset[3:1] of way w into mem_rdata. Write merges mem_wdata bytes per mem_byte_enable and sets dirty[w] (also when mask=00). LRU[set] <= ~w. Go to RESP.
  - Miss: victim = first invalid way (way 0 before way 1), else LRU[set]. Go to WRITEBACK if victim valid && dirty, else ALLOCATE.
- State RESP: mem_resp=1 for exactly this cycle, then IDLE. Hit latency: request sampled at edge N, mem_resp high in cycle N+1.
- State WRITEBACK:
  - pmem_write=1; pmem_address={victim tag, index, 4'b0}; pmem_wdata = victim line.
  - On pmem_resp: clear dirty[victim], go to ALLOCATE.
- State ALLOCATE:
  - pmem_read=1; pmem_address={req tag, index, 4'b0}.
  - On pmem_resp: victim line <= pmem_rdata, tag <= req tag, valid=1, dirty=0. Go to IDLE, which re-evaluates the request and now hits.
- pmem_read and pmem_write are never high together.
- mem_read && mem_write together is illegal; the cache treats it as a write.
- The CPU must not change the address or data while a request is outstanding; the cache does not re-sample them after the first cycle.
- Both ways hit at once is impossible by construction; implementation selects way 0.

Decomposition:
- Add to lc3b_types:
  - lc3b_cache_state enum {cs_idle, cs_resp, cs_writeback, cs_allocate}.
  - lc3b_c_line (alias of lc3b_mem_data).
  - lc3b_c_way (1 bit).
- Sub-module l1_cache_way: one way's tag/valid/dirty/data arrays, hit compare, byte-merge write; instantiated twice.
- Top level holds the FSM, LRU array, victim select and muxing.

Test Plan:
- Cold read 0x1234 -> one ALLOCATE at pmem_address 0x1230; after pmem_resp, mem_resp with the word at offset 4 of the fill line; exactly one mem_resp.
- Read 0x1236 immediately after -> hit, no pmem activity, mem_resp in the cycle after request, correct word 3.
- Write 0xBEEF mask 01 to 0x1234, then read -> low byte 0xEF, high byte unchanged; dirty set.
- Fill set 3 with tags A and B, touch A, access tag C -> B evicted (LRU). If B is dirty, WRITEBACK precedes ALLOCATE with pmem_address={B,3,0}.
- Dirty victim eviction -> pmem_write held until pmem_resp; pmem_wdata equals the modified line; never overlaps pmem_read.
- rst_n low during ALLOCATE -> pmem_read drops asynchronously. Prior hits now miss (valid cleared); state IDLE, mem_resp=0.

Source files
------------

// File: rtl/l1_cache_2way_pkg.sv
// Shared LC-3b cache types: address fields, line/word types and cache FSM states.
package l1_cache_2way_pkg;

  localparam int unsigned WORD_BITS   = 16;
  localparam int unsigned TAG_BITS    = 9;
  localparam int unsigned INDEX_BITS  = 3;
  localparam int unsigned OFFSET_BITS = 4;
  localparam int unsigned LINE_BITS   = 128;

  typedef logic [WORD_BITS-1:0]   lc3b_word;
  typedef logic [1:0]             lc3b_mem_wmask;
  typedef logic [LINE_BITS-1:0]   lc3b_mem_data;
  typedef logic [TAG_BITS-1:0]    lc3b_c_tag;
  typedef logic [INDEX_BITS-1:0]  lc3b_c_index;
  typedef logic [OFFSET_BITS-1:0] lc3b_c_offset;
  typedef lc3b_mem_data           lc3b_c_line;
  typedef logic                   lc3b_c_way;

  typedef enum logic [1:0] {
    cs_idle,
    cs_resp,
    cs_writeback,
    cs_allocate
  } lc3b_cache_state;

  // Line-aligned physical address of a tag/index pair.
  function automatic lc3b_word line_address(input lc3b_c_tag tag, input lc3b_c_index index);
    return {tag, index, 4'b0000};
  endfunction

endpackage

// File: rtl/l1_cache_way.sv
// One cache way: tag/valid/dirty/data arrays, tag compare and byte-merged word write.
module l1_cache_way
  import l1_cache_2way_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [TAG_BITS-1:0]   tag,
  input  logic [2:0]            word_sel,
  input  logic                  wr_en,
  input  logic [1:0]            byte_en,
  input  logic [WORD_BITS-1:0]  wdata,
  input  logic                  fill_en,
  input  logic [LINE_BITS-1:0]  fill_data,
  input  logic                  clean_en,
  output logic                  hit_c,
  output logic                  valid_c,
  output logic                  dirty_c,
  output logic [TAG_BITS-1:0]   tag_c,
  output logic [LINE_BITS-1:0]  line_c
);

  lc3b_c_line          data_q [NUM_SETS];
  lc3b_c_tag           tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  lc3b_c_line          merged;

  assign valid_c = valid_q[index];
  assign dirty_c = dirty_q[index];
  assign tag_c   = tag_q[index];
  assign line_c  = data_q[index];
  assign hit_c   = valid_c && (tag_c == tag);

  // Overlay enabled bytes of the CPU word onto the currently stored line.
  always_comb begin
    merged = line_c;
    if (byte_en[0]) merged[{word_sel, 4'b0000} +: 8] = wdata[7:0];
    if (byte_en[1]) merged[{word_sel, 4'b1000} +: 8] = wdata[15:8];
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[index] <= fill_data;
      tag_q[index]  <= tag;
    end else if (wr_en) begin
      data_q[index] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[index] <= 1'b1;
    end else if (clean_en) begin
      dirty_q[index] <= 1'b0;
    end
  end

endmodule

// File: rtl/l1_cache_2way.sv
// 2-way set-associative write-back/write-allocate L1 cache between LC-3b CPU and line memory.
module l1_cache_2way
  import l1_cache_2way_pkg::*;
#(
  parameter int unsigned NUM_SETS  = 8,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned SETS_FROM_INDEX = 32'(1) << $bits(lc3b_c_index);

  if (NUM_SETS != SETS_FROM_INDEX) begin : g_bad_num_sets
    $error("l1_cache_2way: NUM_SETS must equal 2**$bits(lc3b_c_index)");
  end
  if (LINE_BITS != $bits(lc3b_mem_data)) begin : g_bad_line_bits
    $error("l1_cache_2way: LINE_BITS must equal $bits(lc3b_mem_data)");
  end

  lc3b_cache_state state_q, state_d;
  lc3b_c_tag       req_tag;
  lc3b_c_index     req_index;
  logic [2:0]      word_sel;
  logic            request;
  logic            unused_addr_bit;

  logic [1:0]      hit, way_valid, way_dirty, wr_en, fill_en, clean_en;
  lc3b_c_tag       way_tag  [2];
  lc3b_c_line      way_line [2];

  logic [NUM_SETS-1:0] lru_q;
  lc3b_c_way       victim_q, victim_sel, victim, hit_way;
  logic            hit_any, lru_upd, rdata_ld;
  lc3b_word        rd_word, pmem_address_d;

  assign req_tag         = mem_address[15:7];
  assign req_index       = mem_address[6:4];
  assign word_sel        = mem_address[3:1];
  assign unused_addr_bit = mem_address[0];
  assign request         = mem_read | mem_write;

  for (genvar w = 0; w < 2; w++) begin : g_way
    l1_cache_way #(.NUM_SETS(NUM_SETS)) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .index     (req_index),
      .tag       (req_tag),
      .word_sel  (word_sel),
      .wr_en     (wr_en[w]),
      .byte_en   (mem_byte_enable),
      .wdata     (mem_wdata),
      .fill_en   (fill_en[w]),
      .fill_data (pmem_rdata),
      .clean_en  (clean_en[w]),
      .hit_c     (hit[w]),
      .valid_c   (way_valid[w]),
      .dirty_c   (way_dirty[w]),
      .tag_c     (way_tag[w]),
      .line_c    (way_line[w])
    );
  end

  // Way 0 wins a (theoretically impossible) double hit; first invalid way beats LRU.
  assign hit_any    = |hit;
  assign hit_way    = hit[0] ? 1'b0 : 1'b1;
  assign victim_sel = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_index]);
  assign victim     = (state_q == cs_idle) ? victim_sel : victim_q;
  assign rd_word    = way_line[hit_way][{word_sel, 4'b0000} +: 16];

  // State register plus registered outputs, LRU bits and the latched victim way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= cs_idle;
      lru_q        <= '0;
      victim_q     <= 1'b0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state_q      <= state_d;
      mem_resp     <= (state_d == cs_resp);
      pmem_read    <= (state_d == cs_allocate);
      pmem_write   <= (state_d == cs_writeback);
      pmem_address <= pmem_address_d;
      pmem_wdata   <= way_line[victim];
      if (state_q == cs_idle) victim_q <= victim_sel;
      if (lru_upd) lru_q[req_index] <= ~hit_way;
      if (rdata_ld) mem_rdata <= rd_word;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      cs_idle: begin
        if (request) begin
          if (hit_any) state_d = cs_resp;
          else if (way_valid[victim_sel] && way_dirty[victim_sel]) state_d = cs_writeback;
          else state_d = cs_allocate;
        end
      end
      cs_resp:      state_d = cs_idle;
      cs_writeback: if (pmem_resp) state_d = cs_allocate;
      cs_allocate:  if (pmem_resp) state_d = cs_idle;
      default:      state_d = cs_idle;
    endcase
  end

  // Array controls and next-cycle memory address; read+write together acts as a write.
  always_comb begin
    wr_en          = '0;
    fill_en        = '0;
    clean_en       = '0;
    lru_upd        = 1'b0;
    rdata_ld       = 1'b0;
    pmem_address_d = '0;
    unique case (state_q)
      cs_idle: begin
        if (request && hit_any) begin
          lru_upd = 1'b1;
          if (mem_write) wr_en[hit_way] = 1'b1;
          else rdata_ld = 1'b1;
        end
      end
      cs_writeback: if (pmem_resp) clean_en[victim] = 1'b1;
      cs_allocate:  if (pmem_resp) fill_en[victim] = 1'b1;
      default: ;
    endcase
    if (state_d == cs_writeback) pmem_address_d = line_address(way_tag[victim], req_index);
    else if (state_d == cs_allocate) pmem_address_d = line_address(req_tag, req_index);
  end

endmodule

// File: tb/tb_l1_cache_2way.sv
// Directed + random bench for l1_cache_2way against a set/way/recency model and a line memory.
module tb_l1_cache_2way;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  l1_cache_2way dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  int errors = 0;
  int checks = 0;

  // Reference: backing memory of lines plus per-set way contents and most-recently-used way.
  logic [127:0] mline [logic [15:0]];
  bit           m_valid [8][2];
  bit           m_dirty [8][2];
  logic [8:0]   m_tag   [8][2];
  logic [127:0] m_data  [8][2];
  int           m_mru   [8];

  int           last_nwb, last_nfill;
  logic [15:0]  last_wb_addr, last_fill_addr, last_rdata;
  logic [127:0] last_wb_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] backing(input logic [15:0] la);
    if (!mline.exists(la)) mline[la] = {$urandom, $urandom, $urandom, $urandom};
    return mline[la];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_mru[s] = 1;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  task automatic access(input logic [15:0] addr, input bit wr, input logic [1:0] mask,
                        input logic [15:0] wdata);
    int s, off, way, cyc, dly;
    logic [8:0] t;
    bit hit, exp_wb, got, overlap, prev_w, prev_r;
    logic [15:0] exp_wb_addr, exp_fill_addr, exp_word;
    logic [127:0] exp_wb_data, line;

    s = int'(addr[6:4]);
    off = int'(addr[3:1]);
    t = addr[15:7];
    hit = 1'b0;
    way = 0;
    exp_wb = 1'b0;
    exp_wb_addr = '0;
    exp_wb_data = '0;
    exp_fill_addr = {t, 3'(s), 4'h0};
    for (int w = 0; w < 2; w++)
      if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; way = w; end
    if (!hit) begin
      if (!m_valid[s][0]) way = 0;
      else if (!m_valid[s][1]) way = 1;
      else way = 1 - m_mru[s];
      if (m_valid[s][way] && m_dirty[s][way]) begin
        exp_wb = 1'b1;
        exp_wb_addr = {m_tag[s][way], 3'(s), 4'h0};
        exp_wb_data = m_data[s][way];
        mline[exp_wb_addr] = exp_wb_data;
      end
      m_data[s][way]  = backing(exp_fill_addr);
      m_tag[s][way]   = t;
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = 1'b0;
    end
    line = m_data[s][way];
    exp_word = line[off*16 +: 16];
    if (wr) begin
      if (mask[0]) exp_word[7:0]  = wdata[7:0];
      if (mask[1]) exp_word[15:8] = wdata[15:8];
      line[off*16 +: 16] = exp_word;
      m_data[s][way] = line;
      m_dirty[s][way] = 1'b1;
    end
    m_mru[s] = way;

    mem_address = addr; mem_write = wr; mem_read = !wr;
    mem_byte_enable = mask; mem_wdata = wdata;
    cyc = 0; dly = 0; got = 0; overlap = 0; prev_w = 0; prev_r = 0;
    last_nwb = 0; last_nfill = 0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) overlap = 1'b1;
      if (mem_resp) begin got = 1'b1; last_rdata = mem_rdata; end
      if (pmem_write && !prev_w) begin
        last_nwb++; last_wb_addr = pmem_address; last_wb_data = pmem_wdata;
        dly = $urandom_range(0, 3);
      end
      if (pmem_read && !prev_r) begin
        last_nfill++; last_fill_addr = pmem_address;
        dly = $urandom_range(0, 3);
      end
      prev_w = pmem_write;
      prev_r = pmem_read;
      if (pmem_write || pmem_read) begin
        if (dly == 0) begin
          pmem_resp = 1'b1;
          pmem_rdata = pmem_read ? backing(pmem_address) : {$urandom, $urandom, $urandom, $urandom};
        end else dly--;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;

    chk("resp_seen", 128'(got), 128'(1));
    if (!wr) chk("rdata", 128'(last_rdata), 128'(exp_word));
    chk("wb_count", 128'(last_nwb), 128'(exp_wb));
    if (exp_wb && last_nwb > 0) begin
      chk("wb_addr", 128'(last_wb_addr), 128'(exp_wb_addr));
      chk("wb_data", last_wb_data, exp_wb_data);
    end
    chk("fill_count", 128'(last_nfill), hit ? 128'(0) : 128'(1));
    if (!hit && last_nfill > 0) chk("fill_addr", 128'(last_fill_addr), 128'(exp_fill_addr));
    if (hit) chk("hit_latency", 128'(cyc), 128'(1));
    chk("pmem_overlap", 128'(overlap), 128'(0));
    @(posedge clk); #1;
    chk("resp_single", 128'(mem_resp), 128'(0));
  endtask

  initial begin
    int cyc;
    logic [15:0] a;
    logic [127:0] orig;

    rst_n = 1'b0;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_resp", 128'(mem_resp), 128'(0));
    chk("rst_mem_rdata", 128'(mem_rdata), 128'(0));
    chk("rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_pmem_address", 128'(pmem_address), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold read, then a hit in the same line.
    access(16'h1234, 1'b0, 2'b00, 16'h0000);
    chk("cold_fill_addr", 128'(last_fill_addr), 128'(16'h1230));
    orig = mline[16'h1230];
    chk("cold_word2", 128'(last_rdata), 128'(orig[47:32]));
    access(16'h1236, 1'b0, 2'b00, 16'h0000);
    chk("hit_word3", 128'(last_rdata), 128'(orig[63:48]));

    // Low-byte write then read back.
    access(16'h1234, 1'b1, 2'b01, 16'hBEEF);
    access(16'h1234, 1'b0, 2'b00, 16'h0000);
    chk("wr_low_byte", 128'(last_rdata), 128'({orig[47:40], 8'hEF}));

    // Set 3 recency: B dirty, touch A, C evicts B, then D evicts dirty A.
    access(16'h00B2, 1'b1, 2'b11, 16'h5A5A);
    access(16'h1234, 1'b0, 2'b00, 16'h0000);
    access(16'h0130, 1'b0, 2'b00, 16'h0000);
    chk("lru_wb_B_addr", 128'(last_wb_addr), 128'(16'h00B0));
    chk("lru_fill_C_addr", 128'(last_fill_addr), 128'(16'h0130));
    chk("lru_wb_B_word", 128'(last_wb_data[31:16]), 128'(16'h5A5A));
    access(16'h01B0, 1'b0, 2'b00, 16'h0000);
    chk("dirty_wb_A_addr", 128'(last_wb_addr), 128'(16'h1230));
    chk("dirty_wb_A_byte", 128'(last_wb_data[39:32]), 128'(8'hEF));
    access(16'h1236, 1'b0, 2'b00, 16'h0000);

    // Reset asserted mid-cycle while a fill is outstanding.
    mem_address = 16'h7F00; mem_read = 1'b1;
    cyc = 0;
    while (!pmem_read && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("alloc_seen", 128'(pmem_read), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pmem_read", 128'(pmem_read), 128'(0));
    chk("arst_pmem_write", 128'(pmem_write), 128'(0));
    chk("arst_mem_resp", 128'(mem_resp), 128'(0));
    chk("arst_pmem_address", 128'(pmem_address), 128'(0));
    mem_read = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_read", 128'(pmem_read), 128'(0));
    access(16'h1236, 1'b0, 2'b00, 16'h0000);
    chk("post_rst_miss", 128'(last_nfill), 128'(1));

    // Random traffic over a few tags and sets to force conflicts and evictions.
    for (int i = 0; i < 250; i++) begin
      a = {9'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      access(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
